// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshakes and a 2-entry skid buffer.
// Optional stall/flush statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
  parameter int unsigned       CTRL_W              = 24,
  parameter int unsigned       DATA_W              = 72,
  parameter logic [CTRL_W-1:0] CTRL_NOP            = '0,
  parameter bit                CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int unsigned       CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic drain;

  // in_ready comes straight from the skid flop, so out_ready never reaches upstream.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // NOTE: all state is updated with non-blocking assignments so every branch reads
  // the pre-edge values of main_* and skid_*, regardless of statement order.
  // NOTE: the bundle registers are reset too, because out_ctrl/out_data must show
  // a clean bubble (CTRL_NOP, zero data) the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= CTRL_NOP;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= CTRL_NOP;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= CTRL_NOP;
      skid_ctrl  <= CTRL_NOP;
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (skid_valid) begin
      // Skid full: in_ready is low, so only a drain can move anything.
      if (drain) begin
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_ctrl  <= CTRL_NOP;
        if (CLEAR_DATA_ON_FLUSH) skid_data <= '0;
      end
    end else if (main_valid) begin
      if (drain && accept) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (drain) begin
        main_valid <= 1'b0;
        main_ctrl  <= CTRL_NOP;
        if (CLEAR_DATA_ON_FLUSH) main_data <= '0;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= in_ctrl;
        skid_data  <= in_data;
      end
    end else if (accept) begin
      main_valid <= 1'b1;
      main_ctrl  <= in_ctrl;
      main_data  <= in_data;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (stats_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !out_ready && stall_q != CNT_MAX) stall_q <= stall_q + CNT_ONE;
      if (flush && (main_valid || skid_valid) && flush_q != CNT_MAX) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign stall_cnt        = '0;
  assign flush_cnt        = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised ID/EX-style pipeline register for the 8-bit pipelined core.
- Carries a control bundle and a data bundle between two stages using valid/ready handshakes and a 2-entry skid buffer, so a downstream stall never loses a beat.
- A synchronous flush from the hazard unit squashes all held beats into bubbles.
- Replaces the per-boundary hand-written stage registers (ID/EX, EX/MEM, MEM/WB).

Parameters:
CTRL_W, 24, width of control bundle (alu op, write enables, mux selects, flags).
DATA_W, 72, width of data bundle (operands, imm, pc, sp, register indices, instr).
CTRL_NOP, {CTRL_W{1'b0}}, control value that encodes a bubble.
CLEAR_DATA_ON_FLUSH, 1, 1 = data fields zeroed on flush/bubble; 0 = data held (saves power).
CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
flush  input  1  synchronous squash from hazard unit
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  beat held for downstream
out_ready  input  1  downstream accepts beat
out_ctrl  output  CTRL_W  registered control to next stage
out_data  output  DATA_W  registered data to next stage
stats_clr  input  1  synchronous clear of counters
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
flush_cnt  output  CNT_W  flush events that discarded at least one valid beat

Behaviour:
- Storage: main entry (drives out_*) and skid entry, each with a valid bit.
- Reset (reset=0, async):
  - Both valids are 0 immediately; out_valid=0, in_ready=1.
  - out_ctrl=CTRL_NOP, out_data=0, skid cleared, counters 0.
  - Reset mid-transfer discards all beats; no partial state survives.
- in_ready = ~skid_valid, taken directly from a register with no combinational path from out_ready.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Per-cycle update when flush=0:
  - Main empty, accept: main <= in; out_valid=1 next cycle. Latency is 1 cycle.
  - Main full, drain, skid empty, accept: main <= in (throughput 1 beat/cycle).
  - Main full, drain, skid empty, no accept: main goes empty; out_ctrl <= CTRL_NOP; out_data <= 0 if CLEAR_DATA_ON_FLUSH.
  - Main full, no drain, accept: skid <= in; in_ready=0 next cycle.
  - Skid full, drain: main <= skid; skid empty; in_ready=1 next cycle. No accept is possible this cycle.
  - Skid full, no drain: hold everything.
- Ordering is strictly FIFO; no beat is duplicated or dropped except by flush.
- Flush=1 (highest priority below reset):
  - Both valids <= 0; out_ctrl <= CTRL_NOP; skid ctrl <= CTRL_NOP.
  - Data <= 0 if CLEAR_DATA_ON_FLUSH=1, otherwise data is held.
  - A beat presented in the flush cycle is discarded even if in_valid=1 and in_ready=1.
  - A drain in the same cycle still counts as delivered downstream.
- Whenever out_valid=0, out_ctrl == CTRL_NOP, so downstream may ignore out_valid for write enables.
- Width rules: no truncation or extension; bundles are passed bit-exact.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - flush_cnt increments on a flush cycle where main or skid is valid.
  - Both counters saturate at 2^CNT_W-1.
  - stats_clr zeroes both counters and wins over increment in the same cycle.
- Not defined: counter logic is absent; stall_cnt and flush_cnt are tied to 0 and stats_clr is ignored. Ports remain for a uniform interface.

Test Plan:
- Reset then single beat: release reset, in_valid=1 ctrl=0x00_0041 data=0xA5.. one cycle, out_ready=1 -> out_valid=1 with same values next cycle, then out_valid=0 and out_ctrl=CTRL_NOP.
- Streaming: 8 back-to-back beats data=1..8, out_ready=1 constant -> 8 consecutive outputs 1..8, in_ready never drops.
- Backpressure: stream beats 1..4, out_ready=0 from cycle 2 -> main=1, skid=2, in_ready=0; beats 3 and 4 held upstream; release out_ready -> outputs 1,2,3,4 in order, nothing lost.
- Flush with full skid: main=5, skid=6, assert flush with in_valid=1 data=7 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, out_data=0, in_ready=1; beat 7 never appears; flush_cnt=1 when PIPE_STAGE_STATS_EN is defined.
- Async reset mid-stall: skid full, pull reset low between clock edges -> outputs clear immediately without a clock edge; after release in_ready=1 and counters are 0.
- Counter saturation (CNT_W=4, PIPE_STAGE_STATS_EN defined): hold out_valid=1 & out_ready=0 for 20 cycles -> stall_cnt=15; stats_clr=1 -> stall_cnt=0 next cycle.
